instr_feeder: RTL

- Initiator-side driver for the 16-bit simple processor: owns the processor's din/run inputs and consumes its done output.
- Holds a small program buffer that is loaded word by word. After start, it issues each instruction, supplies the immediate word for mvi, and waits for done before advancing.
- Sits between the testbench or host loader and the processor top; replaces hand-driven stimulus.

---
 rtl/instr_feeder_pkg.sv | 28 ++
 rtl/instr_feeder_mem.sv | 33 +++
 rtl/instr_feeder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/instr_feeder_pkg.sv
`default_nettype none
// ============================================================================
// instr_feeder_pkg : opcodes, FSM state encoding and default widths shared by
//                    the instruction feeder and its program buffer.
// Rev 1.0
// ============================================================================
package instr_feeder_pkg;

  localparam int REG_WIDTH_DEF   = 16;
  localparam int INSTR_WIDTH_DEF = 9;
  localparam int DEPTH_DEF       = 32;
  localparam int ADDR_WIDTH_DEF  = 5;
  localparam int WDOG_CYCLES_DEF = 16;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    IMM   = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_feeder_mem.sv
`default_nettype none
// ============================================================================
// prog_mem : DEPTH x REG_WIDTH program buffer, one synchronous write port and
//            one combinational read port; the array itself is never reset.
// Rev 1.0
// ============================================================================
module prog_mem
  import instr_feeder_pkg::*;
#(
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [REG_WIDTH-1:0]  wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [REG_WIDTH-1:0]  rdata_o
);

  logic [REG_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/instr_feeder.sv
`default_nettype none
// ============================================================================
// instr_feeder : steps a loaded program through the simple processor's
//                din/run/done handshake. Option: INSTR_FEEDER_WATCHDOG_EN.
// Rev 1.0
// ============================================================================
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int REG_WIDTH         = REG_WIDTH_DEF,
  parameter int INSTRUCTION_WIDTH = INSTR_WIDTH_DEF,
  parameter int DEPTH             = DEPTH_DEF,
  parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF
`ifdef INSTR_FEEDER_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES       = WDOG_CYCLES_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [REG_WIDTH-1:0]  load_data,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  start,
  input  logic                  proc_done,
  output logic                  proc_run,
  output logic [REG_WIDTH-1:0]  proc_din,
  output logic [ADDR_WIDTH:0]   pc,
  output logic                  busy,
  output logic                  finished,
  output logic                  err
);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH:0]    pc_q, pc_d, len_q, len_d, pc_inc;
  logic                   busy_q, busy_d, fin_q, fin_d, err_q, err_d;
  logic                   run_q, run_d, gap_q, gap_d;
  logic [REG_WIDTH-1:0]   din_q, din_d, rd_data;
  logic [2:0]             opcode;

  prog_mem #(
    .REG_WIDTH  (REG_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (load_en & ~busy_q),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (pc_d[ADDR_WIDTH-1:0]),
    .rdata_o (rd_data)
  );

  assign pc_inc = pc_q + (ADDR_WIDTH+1)'(1);
  // While in ISSUE the registered din is exactly mem[pc], so decode from it.
  assign opcode = din_q[INSTRUCTION_WIDTH-1 -: 3];

`ifdef INSTR_FEEDER_WATCHDOG_EN
  logic [7:0] wdog_q;
  logic       wdog_hit;

  always_ff @(posedge clk) begin
    if (!rst || state_q != WAIT) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 8'd1;
    end
  end

  assign wdog_hit = (wdog_q == 8'(WDOG_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
      gap_q   <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
      run_q   <= run_d;
      gap_q   <= gap_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    err_d   = err_q;
    gap_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d = prog_len;
          pc_d  = '0;
          err_d = 1'b0;
          if (prog_len == '0) begin
            fin_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        pc_d = pc_inc;
        if (opcode == OP_MVI) begin
          if (pc_inc >= len_q) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = IMM;
          end
        end else begin
          state_d = WAIT;
        end
      end
      IMM: begin
        pc_d    = pc_inc;
        state_d = WAIT;
      end
      WAIT: begin
        // gap_q inserts one quiet cycle so run never follows done directly
        if (gap_q) begin
          state_d = ISSUE;
        end else if (proc_done) begin
          if (pc_q >= len_q) begin
            fin_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            gap_d = 1'b1;
          end
        end
`ifdef INSTR_FEEDER_WATCHDOG_EN
        else if (wdog_hit) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_d = (state_d == ISSUE);
    din_d = din_q;
    if (state_d == ISSUE || state_d == IMM) begin
      din_d = rd_data;
    end
  end

  assign proc_run = run_q;
  assign proc_din = din_q;
  assign pc       = pc_q;
  assign busy     = busy_q;
  assign finished = fin_q;
  assign err      = err_q;

endmodule
`default_nettype wire
